pwm_seq_ctrl: RTL

- Duty-cycle sequencer that feeds compare values to the EF_PWM32 timer.
- Host pushes (cmpA, cmpB, repeat) entries into an internal FIFO.
- The block pops one entry per scheduled period boundary and drives the PWM compare inputs and enable.
- Sits between the bus wrapper or DMA and EF_PWM32. Updates are glitch-free because they land only on period boundaries.

---
 rtl/pwm_seq_pkg.sv | 21 ++
 rtl/pwm_seq_fifo.sv | 72 +++++++
 rtl/pwm_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and default widths for the PWM duty-cycle sequencer.
package pwm_seq_pkg;

  localparam int unsigned PWM_W_DEF = 32;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned RPT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Default-width view of one queued entry, as presented by a bus wrapper or DMA.
  typedef struct packed {
    logic [PWM_W_DEF-1:0] cmpA;
    logic [PWM_W_DEF-1:0] cmpB;
    logic [RPT_W_DEF-1:0] rpt;
  } entry_t;

endpackage

// File: rtl/pwm_seq_fifo.sv
// Synchronous FIFO for sequencer entries; push is dropped when full, pop when empty, flush wins.
module pwm_seq_fifo
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DW    = 2 * PWM_W_DEF + RPT_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_c, do_pop_c;

  assign full_c    = (level_q == LW'(DEPTH));
  assign empty_c   = (level_q == '0);
  assign do_push_c = push && !full_c && !flush;
  assign do_pop_c  = pop && !empty_c && !flush;
  assign rdata_c   = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Duty-cycle sequencer feeding EF_PWM32 compare values on period boundaries.
// Optional `define PWM_SEQ_UFCNT_EN adds a saturating 16-bit underflow counter output (uf_count).
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int unsigned W     = PWM_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned RPT_W = RPT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  input  logic                   period_tick,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [W-1:0]           wr_cmpA,
  input  logic [W-1:0]           wr_cmpB,
  input  logic [RPT_W-1:0]       wr_rpt,
  output logic [W-1:0]           cmpA,
  output logic [W-1:0]           cmpB,
  output logic                   pwm_en,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow,
  output logic                   done
`ifdef PWM_SEQ_UFCNT_EN
  ,
  output logic [15:0]            uf_count
`endif
);

  localparam int unsigned EW = 2 * W + RPT_W;

  state_e           state_q, state_d;
  logic [W-1:0]     cmp_a_q, cmp_a_d;
  logic [W-1:0]     cmp_b_q, cmp_b_d;
  logic             pwm_en_q, pwm_en_d;
  logic             busy_q, busy_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             underflow_q, underflow_d;
  logic             done_q, done_d;

  logic             fifo_pop_c, fifo_flush_c, fifo_full_c, fifo_empty_c;
  logic             load_c, start_acc_c;
  logic [EW-1:0]    head_c;
  logic [W-1:0]     head_a_c, head_b_c;
  logic [RPT_W-1:0] head_rpt_c;

  assign {head_a_c, head_b_c, head_rpt_c} = head_c;
  assign wr_ready = !fifo_full_c;

  pwm_seq_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_valid),
    .pop     (fifo_pop_c),
    .flush   (fifo_flush_c),
    .wdata   ({wr_cmpA, wr_cmpB, wr_rpt}),
    .rdata_c (head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (level)
  );

  always_comb begin
    state_d      = state_q;
    cmp_a_d      = cmp_a_q;
    cmp_b_d      = cmp_b_q;
    pwm_en_d     = pwm_en_q;
    rpt_cnt_d    = rpt_cnt_q;
    stop_pend_d  = stop_pend_q;
    underflow_d  = 1'b0;
    done_d       = 1'b0;
    fifo_pop_c   = 1'b0;
    fifo_flush_c = 1'b0;
    load_c       = 1'b0;
    start_acc_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !fifo_empty_c) begin
          start_acc_c = 1'b1;
          state_d     = ARM;
        end else if (flush) begin
          fifo_flush_c = 1'b1;
        end
      end
      ARM: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (period_tick && !fifo_empty_c) begin
          load_c   = 1'b1;
          pwm_en_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A stop seen on the boundary itself, or pending from earlier, wins over reload.
        if (period_tick) begin
          if (stop_pend_q || stop) begin
            pwm_en_d    = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else if (rpt_cnt_q != '0) begin
            rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
          end else if (!fifo_empty_c) begin
            load_c = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      fifo_pop_c = 1'b1;
      cmp_a_d    = head_a_c;
      cmp_b_d    = head_b_c;
      rpt_cnt_d  = head_rpt_c;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      pwm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      rpt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      pwm_en_q    <= pwm_en_d;
      busy_q      <= busy_d;
      rpt_cnt_q   <= rpt_cnt_d;
      stop_pend_q <= stop_pend_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
    end
  end

  assign cmpA      = cmp_a_q;
  assign cmpB      = cmp_b_q;
  assign pwm_en    = pwm_en_q;
  assign busy      = busy_q;
  assign underflow = underflow_q;
  assign done      = done_q;

`ifdef PWM_SEQ_UFCNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Saturating count of underflow pulses, restarted by each accepted start.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (start_acc_c) begin
      uf_cnt_d = '0;
    end else if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uf_cnt_q <= '0;
    else     uf_cnt_q <= uf_cnt_d;
  end

  assign uf_count = uf_cnt_q;
`endif

endmodule
